// File: rtl/axi_mem_slave.sv
// AXI4 slave backed by an internal word-addressed RAM, full-width beats only.
// Independent read and write FSMs, each holding one outstanding transaction.
module axi_mem_slave #(
    parameter int ADDR_WIDTH   = 32,
    parameter int DATA_WIDTH   = 64,
    parameter int ID_WIDTH     = 4,
    parameter int MEM_DEPTH    = 1024,
    parameter int READ_LATENCY = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    ar_valid,
    output logic                    ar_ready,
    input  logic [ID_WIDTH-1:0]     ar_id,
    input  logic [ADDR_WIDTH-1:0]   ar_addr,
    input  logic [7:0]              ar_len,
    input  logic [1:0]              ar_burst,
    output logic                    r_valid,
    input  logic                    r_ready,
    output logic [ID_WIDTH-1:0]     r_id,
    output logic [DATA_WIDTH-1:0]   r_data,
    output logic [1:0]              r_resp,
    output logic                    r_last,
    input  logic                    aw_valid,
    output logic                    aw_ready,
    input  logic [ID_WIDTH-1:0]     aw_id,
    input  logic [ADDR_WIDTH-1:0]   aw_addr,
    input  logic [7:0]              aw_len,
    input  logic [1:0]              aw_burst,
    input  logic                    w_valid,
    output logic                    w_ready,
    input  logic [DATA_WIDTH-1:0]   w_data,
    input  logic [DATA_WIDTH/8-1:0] w_strb,
    input  logic                    w_last,
    output logic                    b_valid,
    input  logic                    b_ready,
    output logic [ID_WIDTH-1:0]     b_id,
    output logic [1:0]              b_resp
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int OFF    = $clog2(STRB_W);
    localparam int IDX_W  = $clog2(MEM_DEPTH);
    localparam int HI_W   = ADDR_WIDTH - OFF - IDX_W;
    localparam int CNT_W  = (READ_LATENCY < 2) ? 1 : $clog2(READ_LATENCY + 1);
    localparam bit LAT_ZERO = (READ_LATENCY == 0);

    typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_DATA = 2'd2} r_state_t;
    typedef enum logic [1:0] {W_IDLE = 2'd0, W_DATA = 2'd1, W_RESP = 2'd2} w_state_t;

    function automatic logic [ADDR_WIDTH-1:0] next_addr(input logic [ADDR_WIDTH-1:0] addr,
                                                         input logic [7:0] len,
                                                         input logic [1:0] burst);
        logic [ADDR_WIDTH-1:0] stepped;
        logic [ADDR_WIDTH-1:0] wb_mask;
        stepped = addr + ADDR_WIDTH'(STRB_W);
        wb_mask = (ADDR_WIDTH'({1'b0, len} + 9'd1) << OFF) - ADDR_WIDTH'(1);
        case (burst)
            2'b00:   next_addr = addr;
            2'b10:   next_addr = (addr & ~wb_mask) | (stepped & wb_mask);
            default: next_addr = stepped;
        endcase
    endfunction

    function automatic logic in_range(input logic [ADDR_WIDTH-1:0] addr);
        logic [HI_W-1:0] hi;
        hi = addr[ADDR_WIDTH-1 -: HI_W];
        in_range = (hi == {HI_W{1'b0}});
    endfunction

    function automatic logic wrap_bad(input logic [7:0] len, input logic [1:0] burst);
        wrap_bad = (burst == 2'b10) &&
                   !((len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15));
    endfunction

    logic [DATA_WIDTH-1:0] mem_r [MEM_DEPTH];

    // ---------------- read path ----------------
    r_state_t              r_state_r, r_state_s;
    logic [CNT_W-1:0]      r_cnt_r;
    logic [ADDR_WIDTH-1:0] r_addr_r, r_load_addr_s;
    logic [7:0]            r_len_r, r_load_len_s, r_beat_r, r_load_beat_s;
    logic [1:0]            r_burst_r, r_load_burst_s;
    logic                  r_load_s, r_load_bad_s, ar_hs_s, r_hs_s;
    logic                  ar_ready_r, r_valid_r, r_last_r;
    logic [ID_WIDTH-1:0]   r_id_r;
    logic [DATA_WIDTH-1:0] r_data_r;
    logic [1:0]            r_resp_r;

    assign ar_hs_s = ar_valid & ar_ready_r;
    assign r_hs_s  = r_valid_r & r_ready;

    // Read next-state and beat-load decode
    always_comb begin
        r_state_s      = r_state_r;
        r_load_s       = 1'b0;
        r_load_addr_s  = r_addr_r;
        r_load_len_s   = r_len_r;
        r_load_burst_s = r_burst_r;
        r_load_beat_s  = 8'd0;
        case (r_state_r)
            R_IDLE: begin
                if (ar_hs_s) begin
                    r_load_addr_s  = ar_addr;
                    r_load_len_s   = ar_len;
                    r_load_burst_s = ar_burst;
                    if (LAT_ZERO) begin
                        r_state_s = R_DATA;
                        r_load_s  = 1'b1;
                    end else begin
                        r_state_s = R_WAIT;
                    end
                end else begin
                    r_state_s = R_IDLE;
                end
            end
            R_WAIT: begin
                // the count reaching zero after this decrement releases the first beat
                if (r_cnt_r <= CNT_W'(1)) begin
                    r_state_s = R_DATA;
                    r_load_s  = 1'b1;
                end else begin
                    r_state_s = R_WAIT;
                end
            end
            R_DATA: begin
                if (r_hs_s) begin
                    if (r_last_r) begin
                        r_state_s = R_IDLE;
                    end else begin
                        r_load_s      = 1'b1;
                        r_load_addr_s = next_addr(r_addr_r, r_len_r, r_burst_r);
                        r_load_beat_s = r_beat_r + 8'd1;
                    end
                end else begin
                    r_state_s = R_DATA;
                end
            end
            default: r_state_s = R_IDLE;
        endcase
        r_load_bad_s = wrap_bad(r_load_len_s, r_load_burst_s) | ~in_range(r_load_addr_s);
    end

    // Read state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state_r <= R_IDLE;
        end else begin
            r_state_r <= r_state_s;
        end
    end

    // Read command latch, latency counter and registered R channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt_r    <= {CNT_W{1'b0}};
            r_addr_r   <= {ADDR_WIDTH{1'b0}};
            r_len_r    <= 8'd0;
            r_burst_r  <= 2'b00;
            r_beat_r   <= 8'd0;
            r_id_r     <= {ID_WIDTH{1'b0}};
            r_data_r   <= {DATA_WIDTH{1'b0}};
            r_resp_r   <= 2'b00;
            r_last_r   <= 1'b0;
            r_valid_r  <= 1'b0;
            ar_ready_r <= 1'b0;
        end else begin
            if (ar_hs_s) begin
                r_cnt_r   <= CNT_W'(READ_LATENCY);
                r_addr_r  <= ar_addr;
                r_len_r   <= ar_len;
                r_burst_r <= ar_burst;
                r_id_r    <= ar_id;
            end else if (r_state_r == R_WAIT) begin
                r_cnt_r <= r_cnt_r - CNT_W'(1);
            end
            if (r_load_s) begin
                r_addr_r <= r_load_addr_s;
                r_beat_r <= r_load_beat_s;
                r_data_r <= r_load_bad_s ? {DATA_WIDTH{1'b0}} : mem_r[r_load_addr_s[OFF +: IDX_W]];
                r_resp_r <= r_load_bad_s ? 2'b10 : 2'b00;
                r_last_r <= (r_load_beat_s == r_load_len_s);
            end
            r_valid_r  <= (r_state_s == R_DATA);
            ar_ready_r <= (r_state_s == R_IDLE);
        end
    end

    // ---------------- write path ----------------
    w_state_t              w_state_r, w_state_s;
    logic [ADDR_WIDTH-1:0] w_addr_r;
    logic [7:0]            w_len_r, w_beat_r;
    logic [1:0]            w_burst_r;
    logic                  w_wrap_bad_r, w_err_r;
    logic                  aw_hs_s, w_hs_s, b_hs_s, w_final_s, w_bad_s, w_err_s, w_we_s;
    logic                  aw_ready_r, w_ready_r, b_valid_r;
    logic [ID_WIDTH-1:0]   b_id_r;
    logic [1:0]            b_resp_r;

    assign aw_hs_s = aw_valid & aw_ready_r;
    assign w_hs_s  = w_valid & w_ready_r;
    assign b_hs_s  = b_valid_r & b_ready;

    // Write next-state, beat error and RAM write-enable decode
    always_comb begin
        w_state_s = w_state_r;
        w_final_s = (w_beat_r == w_len_r);
        w_bad_s   = w_wrap_bad_r | ~in_range(w_addr_r);
        w_err_s   = w_err_r | w_bad_s | (w_last ^ w_final_s);
        w_we_s    = w_hs_s & ~w_bad_s;
        case (w_state_r)
            W_IDLE: begin
                if (aw_hs_s) w_state_s = W_DATA;
                else         w_state_s = W_IDLE;
            end
            W_DATA: begin
                if (w_hs_s && w_final_s) w_state_s = W_RESP;
                else                     w_state_s = W_DATA;
            end
            W_RESP: begin
                if (b_hs_s) w_state_s = W_IDLE;
                else        w_state_s = W_RESP;
            end
            default: w_state_s = W_IDLE;
        endcase
    end

    // Write state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_state_r <= W_IDLE;
        end else begin
            w_state_r <= w_state_s;
        end
    end

    // Write command latch, beat tracking, sticky error and B channel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            w_addr_r     <= {ADDR_WIDTH{1'b0}};
            w_len_r      <= 8'd0;
            w_burst_r    <= 2'b00;
            w_beat_r     <= 8'd0;
            w_wrap_bad_r <= 1'b0;
            w_err_r      <= 1'b0;
            b_id_r       <= {ID_WIDTH{1'b0}};
            b_resp_r     <= 2'b00;
            aw_ready_r   <= 1'b0;
            w_ready_r    <= 1'b0;
            b_valid_r    <= 1'b0;
        end else begin
            if (aw_hs_s) begin
                w_addr_r     <= aw_addr;
                w_len_r      <= aw_len;
                w_burst_r    <= aw_burst;
                w_beat_r     <= 8'd0;
                w_wrap_bad_r <= wrap_bad(aw_len, aw_burst);
                w_err_r      <= 1'b0;
                b_id_r       <= aw_id;
            end else if (w_hs_s) begin
                w_addr_r <= next_addr(w_addr_r, w_len_r, w_burst_r);
                w_beat_r <= w_beat_r + 8'd1;
                w_err_r  <= w_err_s;
                if (w_final_s) b_resp_r <= w_err_s ? 2'b10 : 2'b00;
            end
            aw_ready_r <= (w_state_s == W_IDLE);
            w_ready_r  <= (w_state_s == W_DATA);
            b_valid_r  <= (w_state_s == W_RESP);
        end
    end

    // Byte-masked RAM write; contents survive reset
    always_ff @(posedge clk) begin
        if (w_we_s) begin
            for (int i = 0; i < STRB_W; i++) begin
                if (w_strb[i]) mem_r[w_addr_r[OFF +: IDX_W]][i*8 +: 8] <= w_data[i*8 +: 8];
            end
        end
    end

    assign ar_ready = ar_ready_r;
    assign r_valid  = r_valid_r;
    assign r_id     = r_id_r;
    assign r_data   = r_data_r;
    assign r_resp   = r_resp_r;
    assign r_last   = r_last_r;
    assign aw_ready = aw_ready_r;
    assign w_ready  = w_ready_r;
    assign b_valid  = b_valid_r;
    assign b_id     = b_id_r;
    assign b_resp   = b_resp_r;
endmodule

// File: tb/tb_axi_mem_slave.sv
// Directed self-checking bench for axi_mem_slave: bursts, wrap, stalls, strobes, errors, reset.
module tb_axi_mem_slave;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ar_valid = 1'b0, ar_ready;
    logic [3:0]  ar_id = 4'd0;
    logic [31:0] ar_addr = 32'd0;
    logic [7:0]  ar_len = 8'd0;
    logic [1:0]  ar_burst = 2'b01;
    logic        r_valid, r_ready = 1'b0, r_last;
    logic [3:0]  r_id;
    logic [63:0] r_data;
    logic [1:0]  r_resp;
    logic        aw_valid = 1'b0, aw_ready;
    logic [3:0]  aw_id = 4'd0;
    logic [31:0] aw_addr = 32'd0;
    logic [7:0]  aw_len = 8'd0;
    logic [1:0]  aw_burst = 2'b01;
    logic        w_valid = 1'b0, w_ready, w_last = 1'b0;
    logic [63:0] w_data = 64'd0;
    logic [7:0]  w_strb = 8'd0;
    logic        b_valid, b_ready = 1'b0;
    logic [3:0]  b_id;
    logic [1:0]  b_resp;

    int vectors = 0;
    int miscompares = 0;

    logic [63:0] wd [16];
    logic [7:0]  ws [16];
    logic [63:0] rd [16];
    logic [1:0]  rr [16];
    logic        rl [16];
    int          rn, rlat, wcount;
    logic [3:0]  rid_c, bid_c;
    logic [1:0]  bresp_c;

    axi_mem_slave #(
        .ADDR_WIDTH(32), .DATA_WIDTH(64), .ID_WIDTH(4), .MEM_DEPTH(1024), .READ_LATENCY(2)
    ) dut (
        .clk(clk), .rst(rst),
        .ar_valid(ar_valid), .ar_ready(ar_ready), .ar_id(ar_id), .ar_addr(ar_addr),
        .ar_len(ar_len), .ar_burst(ar_burst),
        .r_valid(r_valid), .r_ready(r_ready), .r_id(r_id), .r_data(r_data),
        .r_resp(r_resp), .r_last(r_last),
        .aw_valid(aw_valid), .aw_ready(aw_ready), .aw_id(aw_id), .aw_addr(aw_addr),
        .aw_len(aw_len), .aw_burst(aw_burst),
        .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_strb(w_strb), .w_last(w_last),
        .b_valid(b_valid), .b_ready(b_ready), .b_id(b_id), .b_resp(b_resp)
    );

    always #5 clk = ~clk;

    task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                            input logic [3:0] id, input int last_at);
        int g;
        wcount = 0;
        @(negedge clk);
        aw_valid = 1'b1; aw_addr = addr; aw_len = len; aw_burst = burst; aw_id = id;
        g = 0;
        while (!aw_ready && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) begin $display("FAIL aw_handshake: timed out, aw_ready never 1"); miscompares++; vectors++; end
        for (int i = 0; i <= int'(len); i++) begin
            @(negedge clk);
            aw_valid = 1'b0; w_valid = 1'b1; w_data = wd[i]; w_strb = ws[i]; w_last = (i == last_at);
            g = 0;
            while (!w_ready && g < 50) begin @(negedge clk); g++; end
            if (g >= 50) begin
                $display("FAIL w_beat%0d: timed out, w_ready never 1", i); miscompares++; vectors++;
                break;
            end
            wcount++;
        end
        @(negedge clk);
        aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0;
        g = 0;
        while (!b_valid && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) begin $display("FAIL b_wait: timed out, b_valid never 1"); miscompares++; vectors++; end
        bresp_c = b_resp; bid_c = b_id;
        b_ready = 1'b1;
        @(negedge clk);
        b_ready = 1'b0;
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [1:0] burst,
                           input logic [3:0] id);
        int g;
        rn = 0; rlat = 0;
        r_ready = 1'b1;
        @(negedge clk);
        ar_valid = 1'b1; ar_addr = addr; ar_len = len; ar_burst = burst; ar_id = id;
        g = 0;
        while (!ar_ready && g < 50) begin @(negedge clk); g++; end
        if (g >= 50) begin $display("FAIL ar_handshake: timed out, ar_ready never 1"); miscompares++; vectors++; end
        g = 0;
        while (g < 50) begin
            @(negedge clk);
            ar_valid = 1'b0;
            rlat++;
            g++;
            if (r_valid) break;
        end
        g = 0;
        while (rn <= int'(len) && g < 100) begin
            if (r_valid) begin
                if (rn == 0) rid_c = r_id;
                rd[rn] = r_data; rr[rn] = r_resp; rl[rn] = r_last;
                rn++;
            end
            if (rn <= int'(len)) @(negedge clk);
            g++;
        end
        if (rn != int'(len) + 1) begin
            $display("FAIL r_beats: got %0d beats, required %0d", rn, int'(len) + 1); miscompares++; vectors++;
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        if (ar_ready !== 1'b0) begin $display("FAIL rst_ar_ready: got %b want 0", ar_ready); miscompares++; end
        vectors++;
        if (aw_ready !== 1'b0) begin $display("FAIL rst_aw_ready: got %b want 0", aw_ready); miscompares++; end
        vectors++;
        if ({r_valid, r_last, r_resp, r_id, w_ready, b_valid, b_resp, b_id} !== 16'd0) begin
            $display("FAIL rst_outputs: got %h want 0", {r_valid, r_last, r_resp, r_id, w_ready, b_valid, b_resp, b_id});
            miscompares++;
        end
        vectors++;
        if (r_data !== 64'd0) begin $display("FAIL rst_r_data: got %h want 0", r_data); miscompares++; end
        vectors++;
        rst = 1'b1;
        @(negedge clk);
        if ({ar_ready, aw_ready} !== 2'b11) begin
            $display("FAIL rst_release_ready: got %b want 11", {ar_ready, aw_ready}); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_incr();
        wd[0] = 64'h11; wd[1] = 64'h22; wd[2] = 64'h33; wd[3] = 64'h44;
        for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
        do_write(32'h100, 8'd3, 2'b01, 4'h5, 3);
        if (bresp_c !== 2'b00) begin $display("FAIL incr_bresp: got %b want 00", bresp_c); miscompares++; end
        vectors++;
        if (bid_c !== 4'h5) begin $display("FAIL incr_bid: got %h want 5", bid_c); miscompares++; end
        vectors++;
        do_read(32'h100, 8'd3, 2'b01, 4'h9);
        if (rlat !== 3) begin $display("FAIL incr_latency: got %0d want 3", rlat); miscompares++; end
        vectors++;
        if (rid_c !== 4'h9) begin $display("FAIL incr_rid: got %h want 9", rid_c); miscompares++; end
        vectors++;
        for (int i = 0; i < 4; i++) begin
            if (rd[i] !== 64'h11 * (i + 1) || rr[i] !== 2'b00 || rl[i] !== (i == 3)) begin
                $display("FAIL incr_beat%0d: got data=%h resp=%b last=%b want data=%h resp=00 last=%b",
                         i, rd[i], rr[i], rl[i], 64'h11 * (i + 1), (i == 3));
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_wrap();
        logic [63:0] exp_w [4];
        exp_w[0] = 64'h44; exp_w[1] = 64'h11; exp_w[2] = 64'h22; exp_w[3] = 64'h33;
        do_read(32'h118, 8'd3, 2'b10, 4'h1);
        for (int i = 0; i < 4; i++) begin
            if (rd[i] !== exp_w[i] || rr[i] !== 2'b00) begin
                $display("FAIL wrap_beat%0d: got data=%h resp=%b want data=%h resp=00", i, rd[i], rr[i], exp_w[i]);
                miscompares++;
            end
            vectors++;
        end
        do_read(32'h100, 8'd2, 2'b10, 4'h2);
        for (int i = 0; i < 3; i++) begin
            if (rd[i] !== 64'd0 || rr[i] !== 2'b10 || rl[i] !== (i == 2)) begin
                $display("FAIL wrap_badlen_beat%0d: got data=%h resp=%b last=%b want 0/10/%b",
                         i, rd[i], rr[i], rl[i], (i == 2));
                miscompares++;
            end
            vectors++;
        end
    endtask

    task automatic test_stall();
        int g;
        logic aw_done, w_done;
        wd[0] = 64'h0A; wd[1] = 64'h0B; wd[2] = 64'h0C; wd[3] = 64'h0D;
        for (int i = 0; i < 4; i++) ws[i] = 8'hFF;
        do_write(32'h200, 8'd3, 2'b01, 4'h3, 3);
        r_ready = 1'b1;
        @(negedge clk);
        ar_valid = 1'b1; ar_addr = 32'h200; ar_len = 8'd3; ar_burst = 2'b01; ar_id = 4'h4;
        g = 0;
        while (!ar_ready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        ar_valid = 1'b0;
        g = 0;
        while (!r_valid && g < 50) begin @(negedge clk); g++; end
        if (r_data !== 64'h0A) begin $display("FAIL stall_beat0: got %h want 0a", r_data); miscompares++; end
        vectors++;
        @(negedge clk);
        r_ready = 1'b0;
        aw_done = 1'b0; w_done = 1'b0; b_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            if (r_valid !== 1'b1 || r_data !== 64'h0B) begin
                $display("FAIL stall_hold%0d: got valid=%b data=%h want 1/0b", i, r_valid, r_data);
                miscompares++;
            end
            vectors++;
            aw_valid = !aw_done; aw_addr = 32'h210; aw_len = 8'd0; aw_burst = 2'b01; aw_id = 4'h6;
            w_valid = !w_done; w_data = 64'hBEEF; w_strb = 8'hFF; w_last = 1'b1;
            if (aw_valid && aw_ready) aw_done = 1'b1;
            if (w_valid && w_ready) w_done = 1'b1;
            @(negedge clk);
        end
        aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
        r_ready = 1'b1;
        @(negedge clk);
        if (r_data !== 64'hBEEF) begin $display("FAIL stall_next_beat: got %h want beef", r_data); miscompares++; end
        vectors++;
        @(negedge clk);
        if (r_data !== 64'h0D || r_last !== 1'b1) begin
            $display("FAIL stall_last_beat: got data=%h last=%b want 0d/1", r_data, r_last); miscompares++;
        end
        vectors++;
        @(negedge clk);
    endtask

    task automatic test_strb_and_wlast();
        wd[0] = 64'hFFFF_FFFF_FFFF_FFFF; ws[0] = 8'hFF;
        do_write(32'h300, 8'd0, 2'b01, 4'h7, 0);
        wd[0] = 64'd0; ws[0] = 8'h0F;
        do_write(32'h300, 8'd0, 2'b01, 4'h7, 0);
        do_read(32'h300, 8'd0, 2'b01, 4'h7);
        if (rd[0] !== 64'hFFFF_FFFF_0000_0000) begin
            $display("FAIL strb_merge: got %h want ffffffff00000000", rd[0]); miscompares++;
        end
        vectors++;
        for (int i = 0; i < 4; i++) begin wd[i] = 64'h50 + 64'(i); ws[i] = 8'hFF; end
        do_write(32'h180, 8'd3, 2'b01, 4'hC, 1);
        if (wcount !== 4) begin $display("FAIL wlast_early_beats: got %0d want 4", wcount); miscompares++; end
        vectors++;
        if (bresp_c !== 2'b10 || bid_c !== 4'hC) begin
            $display("FAIL wlast_early_bresp: got resp=%b id=%h want 10/c", bresp_c, bid_c); miscompares++;
        end
        vectors++;
    endtask

    task automatic test_oor_and_fixed();
        do_read(32'h2000, 8'd0, 2'b01, 4'hA);
        if (rd[0] !== 64'd0 || rr[0] !== 2'b10 || rl[0] !== 1'b1) begin
            $display("FAIL oor_read: got data=%h resp=%b last=%b want 0/10/1", rd[0], rr[0], rl[0]);
            miscompares++;
        end
        vectors++;
        for (int i = 0; i < 4; i++) begin wd[i] = 64'hA1 + 64'(i); ws[i] = 8'hFF; end
        do_write(32'h40, 8'd3, 2'b00, 4'hB, 3);
        if (bresp_c !== 2'b00) begin $display("FAIL fixed_bresp: got %b want 00", bresp_c); miscompares++; end
        vectors++;
        do_read(32'h40, 8'd0, 2'b01, 4'hB);
        if (rd[0] !== 64'hA4) begin $display("FAIL fixed_data: got %h want a4", rd[0]); miscompares++; end
        vectors++;
    endtask

    task automatic test_reset_mid_burst();
        int g;
        r_ready = 1'b0;
        @(negedge clk);
        ar_valid = 1'b1; ar_addr = 32'h100; ar_len = 8'd3; ar_burst = 2'b01; ar_id = 4'h2;
        g = 0;
        while (!ar_ready && g < 50) begin @(negedge clk); g++; end
        @(negedge clk);
        ar_valid = 1'b0;
        g = 0;
        while (!r_valid && g < 50) begin @(negedge clk); g++; end
        if (r_valid !== 1'b1) begin $display("FAIL midrst_pre: got r_valid=%b want 1", r_valid); miscompares++; end
        vectors++;
        rst = 1'b0;
        #1;
        if (r_valid !== 1'b0 || ar_ready !== 1'b0) begin
            $display("FAIL midrst_async: got r_valid=%b ar_ready=%b want 0/0", r_valid, ar_ready); miscompares++;
        end
        vectors++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        if (ar_ready !== 1'b1 || r_valid !== 1'b0) begin
            $display("FAIL midrst_release: got ar_ready=%b r_valid=%b want 1/0", ar_ready, r_valid); miscompares++;
        end
        vectors++;
        do_read(32'h108, 8'd0, 2'b01, 4'hD);
        if (rd[0] !== 64'h22 || rid_c !== 4'hD) begin
            $display("FAIL midrst_new_read: got data=%h id=%h want 22/d", rd[0], rid_c); miscompares++;
        end
        vectors++;
    endtask

    initial begin
        test_reset();
        test_incr();
        test_wrap();
        test_stall();
        test_strb_and_wlast();
        test_oor_and_fixed();
        test_reset_mid_burst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axi_mem_slave.md
Name: axi_mem_slave

Overview:
AXI4 slave responder backed by an internal word-addressed RAM; the target end of the master-side read/write channels driven by the cache arbiter. Serves the full-width bursts that ICache and DCache issue, in simulation and on FPGA bring-up without external memory. Read and write paths are independent FSMs, each with one outstanding transaction.

Parameters:
ADDR_WIDTH, 32, byte address width
DATA_WIDTH, 64, beat width in bits; power of two, at least 32
ID_WIDTH, 4, transaction ID width
MEM_DEPTH, 1024, RAM depth in DATA_WIDTH words; power of two
READ_LATENCY, 2, cycles from AR handshake to the first r_valid, minus 1

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
ar_valid  in  1  read address valid
ar_ready  out  1  read address ready
ar_id  in  ID_WIDTH  read ID
ar_addr  in  ADDR_WIDTH  start byte address
ar_len  in  8  beats minus 1
ar_burst  in  2  00 FIXED, 01 INCR, 10 WRAP
r_valid  out  1  read data valid
r_ready  in  1  read data ready
r_id  out  ID_WIDTH  echoed ar_id
r_data  out  DATA_WIDTH  read beat
r_resp  out  2  00 OKAY, 10 SLVERR
r_last  out  1  final beat
aw_valid  in  1  write address valid
aw_ready  out  1  write address ready
aw_id  in  ID_WIDTH  write ID
aw_addr  in  ADDR_WIDTH  start byte address
aw_len  in  8  beats minus 1
aw_burst  in  2  burst type, encoded as for ar_burst
w_valid  in  1  write data valid
w_ready  out  1  write data ready
w_data  in  DATA_WIDTH  write beat
w_strb  in  DATA_WIDTH/8  byte enables
w_last  in  1  master's last flag
b_valid  out  1  write response valid
b_ready  in  1  write response ready
b_id  out  ID_WIDTH  echoed aw_id
b_resp  out  2  00 OKAY, 10 SLVERR

Behaviour:
- Beats are always full width, with implicit size log2(DATA_WIDTH/8). Word index is addr[OFF +: log2(MEM_DEPTH)], where OFF=log2(DATA_WIDTH/8). Any addr >= MEM_DEPTH*DATA_WIDTH/8 is out of range. Low OFF address bits are ignored.
- Address step: FIXED keeps addr. INCR adds DATA_WIDTH/8; 11 is treated as INCR. WRAP uses boundary wb=(len+1)*DATA_WIDTH/8: next = (addr & ~(wb-1)) | ((addr+step) & (wb-1)). WRAP with len not in {1,3,7,15} gives SLVERR on every beat and writes nothing.
- Read FSM R_IDLE/R_WAIT/R_DATA. ar_ready=1 only in R_IDLE. On AR handshake, latch id/addr/len/burst and load latency counter=READ_LATENCY. R_WAIT decrements the counter and enters R_DATA when it reads 0. READ_LATENCY=0 goes straight to R_DATA, so r_valid rises the cycle after the handshake.
- R_DATA: r_data/r_resp are registered on beat load (entry, and after each r handshake). They hold stable while r_valid & ~r_ready. A write committing in the same cycle as a load is not visible to that beat. Out-of-range beats return r_data=0 and r_resp=SLVERR. r_last=1 when beat count equals len. Handshake on the last beat returns to R_IDLE; ar_ready=1 the next cycle.
- Write FSM W_IDLE/W_DATA/W_RESP. W_IDLE: aw_ready=1, w_ready=0; W beats arriving before AW wait. W_DATA: aw_ready=0, w_ready=1.
- Each w handshake writes the bytes whose w_strb bit is 1; in-range beats only. Beat len+1 ends the burst regardless of w_last. Sticky SLVERR is set by any out-of-range beat, by w_last=1 on a non-final beat, or by w_last=0 on the final beat.
- W_RESP: b_valid=1, b_id=latched aw_id, b_resp=sticky error. Hold until b_ready, then go to W_IDLE.
- Read and write proceed concurrently; there is no ordering between them.
- Reset (rst=0, async): both FSMs go to IDLE. r_valid, r_last, r_data, r_resp, r_id, w_ready, b_valid, b_resp, b_id all =0. ar_ready and aw_ready =0 while rst=0, and =1 the first cycle after release. In-flight bursts are dropped with no response. RAM contents are not reset.

Test Plan:
- Write INCR aw_addr=0x100, aw_len=3, data 0x11..0x44, all strb -> b_resp=00, b_id echoed. Read of the same burst -> 0x11,0x22,0x33,0x44, r_last on beat 4 only, first r_valid at cycle 3 after AR.
- WRAP read ar_addr=0x118, ar_len=3 -> beat addresses 0x118,0x100,0x108,0x110; ar_len=2 with WRAP -> four-less, three SLVERR beats.
- r_ready held low 5 cycles mid-burst with a concurrent write to the next word -> r_data stable during the stall; the next beat shows the new data.
- w_strb=0x0F over preloaded 0xFFFFFFFFFFFFFFFF with data 0 -> word reads 0xFFFFFFFF00000000. w_last asserted on beat 2 of len=3 -> 4 beats accepted, b_resp=10.
- Read at MEM_DEPTH*8 -> r_data=0, r_resp=10. FIXED len=3 write to 0x40 -> only the last beat's data remains.
- rst pulsed low mid read burst -> r_valid=0 immediately; a new AR is accepted the cycle after release.
